usb_tx_serializer: RTL and testbench

USB_TX_SERIALIZER -- requirements
Module: usb_tx_serializer

---
 rtl/usbSpec.sv | 40 ++++
 rtl/usb_crc16.sv | 37 +++
 rtl/usb_tx_serializer.sv | 179 +++++++++++++++++
 tb/tb_usb_tx_serializer.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/usbSpec.sv
// Shared USB full-speed constants: PID encodings, CRC16 parameters, SYNC pattern
// and the transmit serializer state type.
package usbSpec;

  typedef enum logic [3:0] {
    PID_OUT   = 4'b0001,
    PID_IN    = 4'b1001,
    PID_SOF   = 4'b0101,
    PID_SETUP = 4'b1101,
    PID_DATA0 = 4'b0011,
    PID_DATA1 = 4'b1011,
    PID_DATA2 = 4'b0111,
    PID_MDATA = 4'b1111,
    PID_ACK   = 4'b0010,
    PID_NAK   = 4'b1010,
    PID_STALL = 4'b1110,
    PID_NYET  = 4'b0110
  } usb_pid_e;

  localparam logic [15:0] CRC16_POLY     = 16'h8005;
  localparam logic [15:0] CRC16_INIT     = 16'hFFFF;
  localparam logic [15:0] CRC16_RESIDUAL = 16'h800D;
  localparam logic [7:0]  SYNC_BYTE      = 8'h80;
  localparam logic [2:0]  STUFF_LIMIT    = 3'd6;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SYNC,
    ST_PID,
    ST_DATA,
    ST_CRC,
    ST_EOP
  } tx_state_e;

  // DATA0/1/2/MDATA all share the low PID bits 2'b11.
  function automatic logic is_data_pid(input logic [3:0] pid);
    return pid[1:0] == 2'b11;
  endfunction

endpackage

// File: rtl/usb_crc16.sv
// Serial USB CRC16, one message bit per enable, MSB-side feedback.
// Shared between the transmit serializer and the receiver.
module usb_crc16
  import usbSpec::*;
(
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_init,
  input  logic        i_en,
  input  logic        i_bit,
  output logic [15:0] o_crc
);

  logic [15:0] crc_q, crc_d;
  logic        feedback;

  always_comb begin
    crc_d    = crc_q;
    feedback = crc_q[15] ^ i_bit;
    if (i_init) begin
      crc_d = CRC16_INIT;
    end else if (i_en) begin
      crc_d = {crc_q[14:0], 1'b0} ^ (feedback ? CRC16_POLY : 16'h0000);
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      crc_q <= CRC16_INIT;
    end else begin
      crc_q <= crc_d;
    end
  end

  assign o_crc = crc_q;

endmodule

// File: rtl/usb_tx_serializer.sv
// USB full-speed packet serializer: SYNC, PID, payload, CRC16, bit stuffing,
// NRZI encoding and EOP, advancing one line bit per i_bitStrobe.
module usb_tx_serializer
  import usbSpec::*;
(
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_bitStrobe,
  input  logic       i_txPktBegin,
  input  logic [3:0] i_txPid,
  input  logic       i_txDataAvail,
  output logic       o_txDataGet,
  input  logic [7:0] i_txData,
  output logic       o_txPktEnd,
  output logic       o_usbP,
  output logic       o_usbN,
  output logic       o_usbOe
);

  tx_state_e   state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [7:0]  shreg_q, shreg_d;
  logic [3:0]  pid_q, pid_d;
  logic [2:0]  ones_q, ones_d;
  logic        nrzi_q, nrzi_d;
  logic        usb_p_q, usb_p_d;
  logic        usb_n_q, usb_n_d;
  logic        usb_oe_q, usb_oe_d;
  logic        get_q, get_d;
  logic        end_q, end_d;

  logic        crc_init;
  logic        crc_en;
  logic [15:0] crc;
  logic [3:0]  crc_idx;
  logic        tx_bit;

  usb_crc16 u_crc16 (
    .i_clk  (i_clk),
    .i_rst  (i_rst),
    .i_init (crc_init),
    .i_en   (crc_en),
    .i_bit  (shreg_q[0]),
    .o_crc  (crc)
  );

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    shreg_d  = shreg_q;
    pid_d    = pid_q;
    ones_d   = ones_q;
    nrzi_d   = nrzi_q;
    usb_p_d  = usb_p_q;
    usb_n_d  = usb_n_q;
    usb_oe_d = usb_oe_q;
    get_d    = 1'b0;
    end_d    = 1'b0;
    crc_init = 1'b0;
    crc_en   = 1'b0;
    crc_idx  = 4'd15 - cnt_q;
    tx_bit   = shreg_q[0];

    if (state_q == ST_IDLE) begin
      usb_oe_d = 1'b0;
      usb_p_d  = 1'b1;
      usb_n_d  = 1'b0;
      if (i_txPktBegin) begin
        pid_d    = i_txPid;
        shreg_d  = SYNC_BYTE;
        cnt_d    = '0;
        ones_d   = '0;
        nrzi_d   = 1'b1;
        crc_init = 1'b1;
        state_d  = ST_SYNC;
      end
    end else if (i_bitStrobe) begin
      // A pending stuff bit takes this bit period; the FSM position is held.
      if (ones_q == STUFF_LIMIT) begin
        nrzi_d   = ~nrzi_q;
        ones_d   = '0;
        usb_oe_d = 1'b1;
        usb_p_d  = ~nrzi_q;
        usb_n_d  = nrzi_q;
      end else begin
        case (state_q)
          ST_SYNC, ST_PID, ST_DATA, ST_CRC: begin
            if (state_q == ST_CRC) begin
              tx_bit = ~crc[crc_idx];
            end
            nrzi_d   = tx_bit ? nrzi_q : ~nrzi_q;
            ones_d   = tx_bit ? ones_q + 3'd1 : '0;
            usb_oe_d = 1'b1;
            usb_p_d  = nrzi_d;
            usb_n_d  = ~nrzi_d;
            shreg_d  = shreg_q >> 1;
            cnt_d    = cnt_q + 4'd1;
            crc_en   = (state_q == ST_DATA);
            if (state_q == ST_CRC) begin
              if (cnt_q == 4'd15) begin
                cnt_d   = '0;
                state_d = ST_EOP;
              end
            end else if (cnt_q == 4'd7) begin
              cnt_d = '0;
              if (state_q == ST_SYNC) begin
                state_d = ST_PID;
                shreg_d = {~pid_q, pid_q};
              end else if (state_q == ST_PID && !is_data_pid(pid_q)) begin
                state_d = ST_EOP;
              end else if (i_txDataAvail) begin
                // Byte boundary: the strobe emitting the previous byte's last bit.
                state_d = ST_DATA;
                shreg_d = i_txData;
                get_d   = 1'b1;
              end else begin
                state_d = ST_CRC;
              end
            end
          end
          ST_EOP: begin
            ones_d   = '0;
            cnt_d    = cnt_q + 4'd1;
            usb_oe_d = 1'b1;
            usb_p_d  = 1'b0;
            usb_n_d  = 1'b0;
            if (cnt_q == 4'd2) begin
              usb_p_d = 1'b1;
            end else if (cnt_q == 4'd3) begin
              usb_oe_d = 1'b0;
              usb_p_d  = 1'b1;
              cnt_d    = '0;
              end_d    = 1'b1;
              state_d  = ST_IDLE;
            end
          end
          default: begin
            state_d = ST_IDLE;
          end
        endcase
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      shreg_q  <= '0;
      pid_q    <= '0;
      ones_q   <= '0;
      nrzi_q   <= 1'b1;
      usb_p_q  <= 1'b1;
      usb_n_q  <= 1'b0;
      usb_oe_q <= 1'b0;
      get_q    <= 1'b0;
      end_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      shreg_q  <= shreg_d;
      pid_q    <= pid_d;
      ones_q   <= ones_d;
      nrzi_q   <= nrzi_d;
      usb_p_q  <= usb_p_d;
      usb_n_q  <= usb_n_d;
      usb_oe_q <= usb_oe_d;
      get_q    <= get_d;
      end_q    <= end_d;
    end
  end

  assign o_usbP      = usb_p_q;
  assign o_usbN      = usb_n_q;
  assign o_usbOe     = usb_oe_q;
  assign o_txDataGet = get_q;
  assign o_txPktEnd  = end_q;

endmodule

// File: tb/tb_usb_tx_serializer.sv
// Randomized bench for usb_tx_serializer: a bit-list packet model plus a
// golden NRZI/unstuff decoder that recovers SYNC, PID, payload and CRC residual.
module tb_usb_tx_serializer;
  import usbSpec::*;

  logic       i_clk = 1'b0;
  logic       i_rst = 1'b1;
  logic       i_bitStrobe = 1'b0;
  logic       i_txPktBegin = 1'b0;
  logic [3:0] i_txPid = 4'h0;
  logic       i_txDataAvail = 1'b0;
  logic       o_txDataGet;
  logic [7:0] i_txData = 8'h00;
  logic       o_txPktEnd;
  logic       o_usbP;
  logic       o_usbN;
  logic       o_usbOe;

  usb_tx_serializer dut (
    .i_clk         (i_clk),
    .i_rst         (i_rst),
    .i_bitStrobe   (i_bitStrobe),
    .i_txPktBegin  (i_txPktBegin),
    .i_txPid       (i_txPid),
    .i_txDataAvail (i_txDataAvail),
    .o_txDataGet   (o_txDataGet),
    .i_txData      (i_txData),
    .o_txPktEnd    (o_txPktEnd),
    .o_usbP        (o_usbP),
    .o_usbN        (o_usbN),
    .o_usbOe       (o_usbOe)
  );

  always #5 i_clk = ~i_clk;

  int n_checks = 0;
  int n_pass   = 0;

  logic [2:0] exp_line [256];
  logic [2:0] cap      [256];
  int         exp_len;
  int         exp_get  [16];
  int         exp_ngets;
  logic [7:0] pay      [16];
  int         cur_n;
  int         up_idx;
  int         ngets, nends, last_s, obs_end, obs_oe;
  int         obs_get  [16];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  function automatic logic [15:0] crc_step(input logic [15:0] c, input logic b);
    logic fb;
    fb = c[15] ^ b;
    return {c[14:0], 1'b0} ^ (fb ? CRC16_POLY : 16'h0000);
  endfunction

  // One clock: observe the registered outputs, then play the upstream byte source.
  task automatic tick();
    @(negedge i_clk);
    if (o_txDataGet === 1'b1) begin
      if (ngets < 16) obs_get[ngets] = last_s;
      ngets++;
      up_idx++;
    end
    if (o_txPktEnd === 1'b1) begin
      obs_end = last_s;
      nends++;
    end
    i_txDataAvail = (up_idx < cur_n);
    i_txData      = (up_idx < cur_n) ? pay[up_idx] : 8'($urandom);
  endtask

  // Expected line from the packet rules: bit list, stuffing, NRZI, EOP.
  task automatic build_expect(input logic [3:0] pid, input int n);
    logic       pre [300];
    int         np, run, L;
    logic [15:0] c;
    logic [7:0] b8;
    logic       lvl, is_data;
    np = 0;
    b8 = SYNC_BYTE;
    for (int i = 0; i < 8; i++) begin pre[np] = b8[i]; np++; end
    b8 = {~pid, pid};
    for (int i = 0; i < 8; i++) begin pre[np] = b8[i]; np++; end
    is_data = (pid[1:0] == 2'b11);
    if (is_data) begin
      c = 16'hFFFF;
      for (int k = 0; k < n; k++) begin
        b8 = pay[k];
        for (int i = 0; i < 8; i++) begin
          pre[np] = b8[i]; np++;
          c = crc_step(c, b8[i]);
        end
      end
      for (int i = 0; i < 16; i++) begin pre[np] = ~c[15-i]; np++; end
    end
    lvl = 1'b1; run = 0; L = 0; exp_ngets = 0;
    for (int i = 0; i < np; i++) begin
      if (!pre[i]) lvl = ~lvl;
      exp_line[L] = {1'b1, lvl, ~lvl}; L++;
      if (is_data && i >= 15 && ((i - 15) % 8) == 0 && ((i - 15) / 8) < n) begin
        exp_get[(i - 15) / 8] = L - 1;
        exp_ngets++;
      end
      run = pre[i] ? run + 1 : 0;
      if (run == 6) begin
        lvl = ~lvl;
        exp_line[L] = {1'b1, lvl, ~lvl}; L++;
        run = 0;
      end
    end
    exp_line[L] = 3'b100; L++;
    exp_line[L] = 3'b100; L++;
    exp_line[L] = 3'b110; L++;
    exp_len = L;
  endtask

  // Golden receiver: NRZI decode, drop stuff bits, check fields and CRC residual.
  task automatic decode_check(input logic [3:0] pid, input int n);
    logic        d [300];
    int          nd, run;
    logic        prev, b;
    logic [7:0]  by;
    logic [15:0] c;
    nd = 0; run = 0; prev = 1'b1;
    for (int i = 0; i < exp_len; i++) begin
      if (cap[i][1:0] == 2'b00) break;
      b = (cap[i][1] == prev);
      prev = cap[i][1];
      if (run == 6) begin
        run = 0;
      end else begin
        d[nd] = b; nd++;
        run = b ? run + 1 : 0;
      end
    end
    check("dec_len", nd, (pid[1:0] == 2'b11) ? 32 + 8 * n : 16);
    if (nd >= 16) begin
      for (int i = 0; i < 8; i++) by[i] = d[i];
      check("dec_sync", by, SYNC_BYTE);
      for (int i = 0; i < 8; i++) by[i] = d[8 + i];
      check("dec_pid", by, {~pid, pid});
    end
    if (pid[1:0] == 2'b11 && nd == 32 + 8 * n) begin
      c = 16'hFFFF;
      for (int k = 0; k < n; k++) begin
        for (int i = 0; i < 8; i++) by[i] = d[16 + 8 * k + i];
        check("dec_byte", by, pay[k]);
      end
      for (int i = 16; i < nd; i++) c = crc_step(c, d[i]);
      check("dec_residual", c, CRC16_RESIDUAL);
    end
  endtask

  task automatic run_pkt(input logic [3:0] pid, input int n, input int per,
                         input bit busy, input int abort_at, input bit tail);
    int g0;
    cur_n = n; up_idx = 0;
    build_expect(pid, n);
    ngets = 0; nends = 0; obs_oe = 0; obs_end = -1; last_s = -1;
    i_txDataAvail = (n > 0);
    i_txData      = pay[0];
    i_txPid = pid; i_txPktBegin = 1'b1;
    tick();
    i_txPktBegin = 1'b0; i_txPid = 4'($urandom);
    for (int s = 0; s <= exp_len; s++) begin
      for (int w = 0; w < per - 1; w++) begin
        i_txPktBegin = (busy && s == 5 && w == 0);
        tick();
      end
      i_txPktBegin = 1'b0;
      i_bitStrobe  = 1'b1;
      last_s = s;
      tick();
      i_bitStrobe = 1'b0;
      if (o_usbOe === 1'b1) obs_oe++;
      if (s == abort_at) begin
        g0 = ngets;
        i_rst = 1'b1;
        tick();
        check("abort_line", {o_usbOe, o_usbP, o_usbN}, 3'b010);
        check("abort_end", o_txPktEnd, 1'b0);
        for (int k = 0; k < 4; k++) begin
          i_bitStrobe = 1'b1; tick(); i_bitStrobe = 1'b0; tick();
        end
        i_rst = 1'b0;
        for (int k = 0; k < 12; k++) begin
          i_bitStrobe = 1'b1; tick(); i_bitStrobe = 1'b0; tick();
        end
        check("abort_idle", {o_usbOe, o_usbP, o_usbN}, 3'b010);
        check("abort_no_end", nends, 0);
        check("abort_no_get", ngets, g0);
        return;
      end
      if (s < exp_len) begin
        cap[s] = {o_usbOe, o_usbP, o_usbN};
        check("line_bit", {o_usbOe, o_usbP, o_usbN}, exp_line[s]);
      end else begin
        check("idle_after", {o_usbOe, o_usbP, o_usbN}, 3'b010);
      end
    end
    last_s = 999;
    if (tail) begin
      for (int k = 0; k < 6; k++) begin
        i_bitStrobe = (k % 2 == 0); tick();
      end
      i_bitStrobe = 1'b0;
      check("tail_idle", {o_usbOe, o_usbP, o_usbN}, 3'b010);
    end
    check("oe_bits", obs_oe, exp_len);
    check("end_count", nends, 1);
    check("end_pos", obs_end, exp_len);
    check("get_count", ngets, exp_ngets);
    for (int k = 0; k < exp_ngets && k < ngets && k < 16; k++)
      check("get_pos", obs_get[k], exp_get[k]);
    decode_check(pid, n);
  endtask

  logic [3:0] pid_list [12];

  initial begin
    pid_list = '{PID_OUT, PID_IN, PID_SOF, PID_SETUP, PID_DATA0, PID_DATA1,
                 PID_DATA2, PID_MDATA, PID_ACK, PID_NAK, PID_STALL, PID_NYET};
    cur_n = 0; up_idx = 0; ngets = 0; nends = 0; last_s = -1;
    for (int k = 0; k < 16; k++) pay[k] = 8'h00;

    i_rst = 1'b1;
    for (int k = 0; k < 3; k++) tick();
    check("reset_line", {o_usbOe, o_usbP, o_usbN}, 3'b010);
    check("reset_get", o_txDataGet, 1'b0);
    check("reset_end", o_txPktEnd, 1'b0);
    i_rst = 1'b0;
    tick();

    run_pkt(PID_ACK, 0, 3, 1'b0, -1, 1'b1);
    run_pkt(PID_DATA1, 0, 2, 1'b0, -1, 1'b1);
    pay[0] = 8'hFF; pay[1] = 8'hFF;
    run_pkt(PID_DATA0, 2, 3, 1'b0, -1, 1'b1);
    for (int k = 0; k < 4; k++) pay[k] = 8'($urandom);
    run_pkt(PID_DATA0, 4, 4, 1'b0, -1, 1'b1);
    pay[0] = 8'h5A; pay[1] = 8'hFE;
    run_pkt(PID_DATA1, 2, 3, 1'b1, -1, 1'b1);
    for (int k = 0; k < 5; k++) pay[k] = 8'($urandom);
    run_pkt(PID_DATA0, 5, 2, 1'b0, 30, 1'b1);
    run_pkt(PID_ACK, 0, 2, 1'b0, -1, 1'b0);
    run_pkt(PID_IN, 0, 2, 1'b0, -1, 1'b1);

    for (int r = 0; r < 12; r++) begin
      int n;
      logic [3:0] p;
      p = pid_list[$urandom_range(0, 11)];
      n = (p[1:0] == 2'b11) ? int'($urandom_range(0, 8)) : 0;
      for (int k = 0; k < n; k++)
        pay[k] = ($urandom_range(0, 2) == 0) ? 8'hFF : 8'($urandom);
      run_pkt(p, n, int'($urandom_range(2, 5)), 1'b0, -1, (r % 3) != 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
